io_sequencer: RTL and testbench

Controller that sequences the processor's Input, Output and Halt instructions against the board I/O (10 switches, Enter key, 8-digit display driver). It sits between the CPU control unit and the seven-segment display block. It stalls the CPU while an I/O instruction waits for the operator, debounces Enter, and snapshots switch data. It also latches output values and drives the display block's Input/Output/Halt mode lines.

---
 rtl/io_seq_pkg.sv | 21 ++
 rtl/io_sequencer_if.sv | 28 ++
 rtl/enter_debounce.sv | 60 ++++++
 rtl/io_sequencer.sv | 148 ++++++++++++++
 tb/tb_io_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_seq_pkg.sv
// Shared types and constants for the I/O sequencer.
//   io_seq_state_t         : sequencer FSM state encoding
//   IN_WIDTH               : number of board switches
//   DEFAULT_DEBOUNCE_CYCLES: default Enter debounce length (clock cycles)
//   DEFAULT_TIMEOUT_CYCLES : default Output auto-acknowledge delay (clock cycles)
package io_seq_pkg;

  localparam int unsigned IN_WIDTH                = 10;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 50000000;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIn,
    StWaitOut,
    StAck,
    StRelease,
    StHalted
  } io_seq_state_t;

endpackage

// File: rtl/io_sequencer_if.sv
// CPU-side handshake between the control unit and the I/O sequencer.
//   in_req, out_req, halt_req : instruction requests (levels) from the CPU
//   out_value                 : value to display for Output
//   stall                     : CPU hold while an I/O instruction is pending or halted
//   io_ack                    : one-cycle completion pulse
//   in_data                   : switch snapshot returned by Input
// Modports: master = CPU control unit, slave = io_sequencer.
interface io_sequencer_if;

  logic        in_req;
  logic        out_req;
  logic        halt_req;
  logic [31:0] out_value;
  logic        stall;
  logic        io_ack;
  logic [31:0] in_data;

  modport master (
    output in_req, out_req, halt_req, out_value,
    input  stall, io_ack, in_data
  );

  modport slave (
    input  in_req, out_req, halt_req, out_value,
    output stall, io_ack, in_data
  );

endinterface

// File: rtl/enter_debounce.sv
// Enter key conditioning: 2-FF synchronizer followed by a stability counter.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   enter_raw        : raw asynchronous Enter key (active high)
//   level            : debounced Enter level
//   press_evt        : one-cycle pulse on a debounced rising edge (aligned with level rising)
// A level change is accepted only after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the current debounced level.
module enter_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enter_raw,
  output logic level,
  output logic press_evt
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax =
      CntW'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    // Counter only runs while the synchronized level disagrees with the debounced one.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], enter_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level     = level_q;
  assign press_evt = press_q;

endmodule

// File: rtl/io_sequencer.sv
// Sequences Input / Output / Halt instructions against the board I/O.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   cpu          : io_sequencer_if.slave (requests, out_value, stall, io_ack, in_data)
//   sw           : raw switch levels sw9..sw0
//   enter_raw    : raw asynchronous Enter key
//   out_hold     : latched Output value for the display block
//   disp_input, disp_output, disp_halt : one-hot display mode (all low = idle dashes)
// Optional feature: define IO_SEQ_TIMEOUT_EN to auto-acknowledge Output after
// TIMEOUT_CYCLES cycles in the output wait without an Enter press.
module io_sequencer
  import io_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  io_sequencer_if.slave       cpu,
  input  logic [IN_WIDTH-1:0] sw,
  input  logic                enter_raw,
  output logic [31:0]         out_hold,
  output logic                disp_input,
  output logic                disp_output,
  output logic                disp_halt
);

  io_seq_state_t state_q, state_d;
  logic [31:0]   in_data_q, in_data_d;
  logic [31:0]   out_hold_q, out_hold_d;
  logic          stall_q, stall_d;
  logic          enter_level;
  logic          press_evt;
  logic          tmo_hit;

  enter_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_debounce (
    .clk      (clk),
    .reset    (reset),
    .enter_raw(enter_raw),
    .level    (enter_level),
    .press_evt(press_evt)
  );

`ifdef IO_SEQ_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Held at zero outside the output wait, so it starts from zero on every entry.
  always_comb begin
    tmo_d = '0;
    if (state_q == StWaitOut) begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (state_q == StWaitOut) &&
                   (tmo_q == 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    in_data_d  = in_data_q;
    out_hold_d = out_hold_q;
    // Halt overrides everything and aborts any pending wait without an acknowledge.
    if (cpu.halt_req) begin
      state_d = StHalted;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu.in_req) begin
            state_d = StWaitIn;
          end else if (cpu.out_req) begin
            state_d    = StWaitOut;
            out_hold_d = cpu.out_value;
          end
        end
        StWaitIn: begin
          if (!cpu.in_req) begin
            state_d = StIdle;
          end else if (press_evt) begin
            state_d   = StAck;
            in_data_d = {{(32 - IN_WIDTH){1'b0}}, sw};
          end
        end
        StWaitOut: begin
          if (!cpu.out_req) begin
            state_d = StIdle;
          end else if (press_evt || tmo_hit) begin
            state_d = StAck;
          end
        end
        StAck: begin
          // A still-held Enter must be released before another instruction can complete.
          state_d = enter_level ? StRelease : StIdle;
        end
        StRelease: begin
          if (!enter_level) begin
            state_d = StIdle;
          end
        end
        StHalted: begin
          state_d = StHalted;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign stall_d = (state_d == StWaitIn) || (state_d == StWaitOut) || (state_d == StHalted);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      in_data_q  <= '0;
      out_hold_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_data_q  <= in_data_d;
      out_hold_q <= out_hold_d;
      stall_q    <= stall_d;
    end
  end

  assign cpu.stall   = stall_q;
  assign cpu.io_ack  = (state_q == StAck);
  assign cpu.in_data = in_data_q;
  assign out_hold    = out_hold_q;
  assign disp_input  = (state_q == StWaitIn);
  assign disp_output = (state_q == StWaitOut);
  assign disp_halt   = (state_q == StHalted);

endmodule

// File: tb/tb_io_sequencer.sv
// Directed self-checking bench for io_sequencer (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_io_sequencer;

  logic       clk;
  logic       reset;
  logic [9:0] sw;
  logic       enter_raw;
  logic [31:0] out_hold;
  logic       disp_input;
  logic       disp_output;
  logic       disp_halt;

  int checks = 0;
  int errors = 0;
  int ack_total = 0;

  io_sequencer_if cpu_if ();

  io_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu_if),
    .sw         (sw),
    .enter_raw  (enter_raw),
    .out_hold   (out_hold),
    .disp_input (disp_input),
    .disp_output(disp_output),
    .disp_halt  (disp_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu_if.io_ack) ack_total <= ack_total + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of ticks until io_ack is seen, 0 if it never came.
  task automatic wait_ack(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cpu_if.io_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [2:0] disp();
    return {disp_input, disp_output, disp_halt};
  endfunction

  int lat;
  int base;

  initial begin
    reset            = 1'b0;
    sw               = '0;
    enter_raw        = 1'b0;
    cpu_if.in_req    = 1'b0;
    cpu_if.out_req   = 1'b0;
    cpu_if.halt_req  = 1'b0;
    cpu_if.out_value = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Reset state
    check_eq("rst_stall", cpu_if.stall, 0);
    check_eq("rst_ack", cpu_if.io_ack, 0);
    check_eq("rst_in_data", cpu_if.in_data, 0);
    check_eq("rst_out_hold", out_hold, 0);
    check_eq("rst_disp", disp(), 3'b000);

    // Input with a clean press
    base          = ack_total;
    sw            = 10'h2A5;
    cpu_if.in_req = 1'b1;
    tick();
    check_eq("in_stall", cpu_if.stall, 1);
    check_eq("in_disp", disp(), 3'b100);
    enter_raw = 1'b1;
    wait_ack(lat);
    check_eq("in_ack_lat", lat, 7);
    check_eq("in_data", cpu_if.in_data, 32'h2A5);
    check_eq("in_ack_stall", cpu_if.stall, 0);
    check_eq("in_ack_disp", disp(), 3'b000);
    cpu_if.in_req = 1'b0;
    tick();
    check_eq("in_ack_pulse", cpu_if.io_ack, 0);
    check_eq("in_ack_count", ack_total - base, 1);
    repeat (2) tick();
    enter_raw = 1'b0;
    repeat (10) tick();
    check_eq("in_idle_stall", cpu_if.stall, 0);

    // Output with a short glitch before a clean press
    base             = ack_total;
    cpu_if.out_value = 32'd1234;
    cpu_if.out_req   = 1'b1;
    tick();
    check_eq("out_disp", disp(), 3'b010);
    check_eq("out_hold_latch", out_hold, 32'd1234);
    enter_raw = 1'b1;
    repeat (2) tick();
    enter_raw = 1'b0;
    repeat (4) tick();
    check_eq("glitch_no_ack", ack_total - base, 0);
    check_eq("glitch_stall", cpu_if.stall, 1);
    enter_raw = 1'b1;
    wait_ack(lat);
    check_eq("out_ack_lat", lat, 7);
    check_eq("out_hold_ack", out_hold, 32'd1234);
    cpu_if.out_req = 1'b0;
    tick();
    check_eq("out_ack_count", ack_total - base, 1);
    enter_raw = 1'b0;
    repeat (10) tick();
    check_eq("out_hold_keep", out_hold, 32'd1234);

    // Enter held across two consecutive Input instructions
    sw            = 10'h0F0;
    cpu_if.in_req = 1'b1;
    tick();
    enter_raw = 1'b1;
    wait_ack(lat);
    check_eq("held_first_lat", lat, 7);
    check_eq("held_first_data", cpu_if.in_data, 32'h0F0);
    cpu_if.in_req = 1'b0;
    tick();
    base          = ack_total;
    sw            = 10'h15A;
    cpu_if.in_req = 1'b1;
    repeat (10) tick();
    check_eq("held_no_second_ack", ack_total - base, 0);
    check_eq("held_data_keep", cpu_if.in_data, 32'h0F0);
    enter_raw = 1'b0;
    repeat (10) tick();
    check_eq("held_second_stall", cpu_if.stall, 1);
    check_eq("held_second_disp", disp(), 3'b100);
    check_eq("held_still_no_ack", ack_total - base, 0);
    enter_raw = 1'b1;
    wait_ack(lat);
    check_eq("held_second_lat", lat, 7);
    check_eq("held_second_data", cpu_if.in_data, 32'h15A);
    cpu_if.in_req = 1'b0;
    tick();
    enter_raw = 1'b0;
    repeat (10) tick();

    // Halt while waiting for Input, then reset
    base          = ack_total;
    sw            = 10'h3FF;
    cpu_if.in_req = 1'b1;
    tick();
    cpu_if.halt_req = 1'b1;
    tick();
    check_eq("halt_disp", disp(), 3'b001);
    check_eq("halt_stall", cpu_if.stall, 1);
    check_eq("halt_ack", cpu_if.io_ack, 0);
    cpu_if.halt_req = 1'b0;
    cpu_if.in_req   = 1'b0;
    repeat (5) tick();
    check_eq("halt_sticky", disp(), 3'b001);
    check_eq("halt_no_ack", ack_total - base, 0);
    check_eq("halt_in_data", cpu_if.in_data, 32'h15A);
    reset = 1'b0;
    #1;
    check_eq("async_rst_stall", cpu_if.stall, 0);
    check_eq("async_rst_disp", disp(), 3'b000);
    check_eq("async_rst_in_data", cpu_if.in_data, 0);
    check_eq("async_rst_out_hold", out_hold, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_eq("post_rst_stall", cpu_if.stall, 0);

    // Input and Output requested together: Input wins
    cpu_if.out_value = 32'hDEADBEEF;
    cpu_if.in_req    = 1'b1;
    cpu_if.out_req   = 1'b1;
    tick();
    check_eq("prio_disp", disp(), 3'b100);
    check_eq("prio_out_hold", out_hold, 0);
    cpu_if.in_req  = 1'b0;
    cpu_if.out_req = 1'b0;
    tick();
    check_eq("prio_drop_stall", cpu_if.stall, 0);
    check_eq("prio_drop_disp", disp(), 3'b000);
    tick();

    // Output with no press
    base             = ack_total;
    cpu_if.out_value = 32'd55;
    cpu_if.out_req   = 1'b1;
    tick();
`ifdef IO_SEQ_TIMEOUT_EN
    wait_ack(lat);
    check_eq("tmo_ack_lat", lat, 20);
    cpu_if.out_req = 1'b0;
    tick();
    check_eq("tmo_ack_count", ack_total - base, 1);
`else
    repeat (1000) tick();
    check_eq("no_tmo_ack", ack_total - base, 0);
    check_eq("no_tmo_stall", cpu_if.stall, 1);
    check_eq("no_tmo_disp", disp(), 3'b010);
    cpu_if.out_req = 1'b0;
    tick();
`endif
    check_eq("final_stall", cpu_if.stall, 0);
    check_eq("final_out_hold", out_hold, 32'd55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
